// File: rtl/proj_direct_op.sv
// ---------------------------------------------------------------------------
// proj_direct_op
//
// Purpose:
//   16-state Moore FSM that steps through the 4-bit reflected Gray code.
//   The state register itself is the output ("direct output" encoding), so
//   y has no decode logic and no combinational path from any input.
//   Consecutive outputs, including the wrap from S15 back to S0, differ in
//   exactly one bit.
//
// Ports:
//   clk  in   1  sole clock; all state updates on the rising edge
//   rst  in   1  asynchronous active-low reset, forces S0 (y = 0000)
//   ld   in   1  synchronous restart; returns to S0 on the next rising edge
//                and takes priority over advancing
//   y    out  4  current state code
// ---------------------------------------------------------------------------
module proj_direct_op (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  output logic [3:0] y
);

  // Each state's code is its Gray-code value, so the register is the output.
  typedef enum logic [3:0] {
    S0  = 4'b0000,
    S1  = 4'b0001,
    S2  = 4'b0011,
    S3  = 4'b0010,
    S4  = 4'b0110,
    S5  = 4'b0111,
    S6  = 4'b0101,
    S7  = 4'b0100,
    S8  = 4'b1100,
    S9  = 4'b1101,
    S10 = 4'b1111,
    S11 = 4'b1110,
    S12 = 4'b1010,
    S13 = 4'b1011,
    S14 = 4'b1001,
    S15 = 4'b1000
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register: reset acts immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: ld restarts the sequence and wins over advancing.
  // The default branch is unreachable because all 16 codes are states, but it
  // keeps the decode fully specified.
  always_comb begin
    state_d = S0;
    if (ld) begin
      state_d = S0;
    end else begin
      unique case (state_q)
        S0:      state_d = S1;
        S1:      state_d = S2;
        S2:      state_d = S3;
        S3:      state_d = S4;
        S4:      state_d = S5;
        S5:      state_d = S6;
        S6:      state_d = S7;
        S7:      state_d = S8;
        S8:      state_d = S9;
        S9:      state_d = S10;
        S10:     state_d = S11;
        S11:     state_d = S12;
        S12:     state_d = S13;
        S13:     state_d = S14;
        S14:     state_d = S15;
        S15:     state_d = S0;
        default: state_d = S0;
      endcase
    end
  end

  // Output logic: the state code is presented unchanged.
  always_comb begin
    y = state_q;
  end

endmodule

// File: tb/tb_proj_direct_op.sv
// ---------------------------------------------------------------------------
// tb_proj_direct_op
//
// Purpose:
//   Randomized self-checking bench for proj_direct_op. A driver issues one
//   (rst, ld) pair per clock and pushes the response predicted by a position
//   counter model into a scoreboard queue. A monitor pops one entry per cycle
//   on the falling edge and compares it with y. Asynchronous reset
//   assertion is checked directly between edges.
// ---------------------------------------------------------------------------
module tb_proj_direct_op;

  logic       clk;
  logic       rst;
  logic       ld;
  logic [3:0] y;

  // One predicted response: expected code and whether it is an advance step
  // (advance steps must change exactly one bit from the previous output).
  typedef struct {
    logic [3:0] expY;
    bit         isAdvance;
  } expect_t;

  expect_t    scoreQ[$];
  int         checkCount = 0;
  int         errorCount = 0;
  int         modelPos   = 0;
  bit         driverDone = 0;

  proj_direct_op dut (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .y   (y)
  );

  // 10-unit clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Gray code of a sequence position, computed arithmetically.
  function automatic logic [3:0] grayOf(input int pos);
    int g;
    g = pos ^ (pos >> 1);
    return g[3:0];
  endfunction

  // Single comparison point shared by the monitor and the direct checks.
  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: y=%b expected=%b at t=%0t", name, actual,
               expected, $time);
    end
  endtask

  // Drive one cycle of stimulus, then record the predicted post-edge output.
  task automatic applyStimulus(input logic rstVal, input logic ldVal);
    expect_t e;
    @(negedge clk);
    rst = rstVal;
    ld  = ldVal;
    @(posedge clk);
    e.isAdvance = 1'b0;
    if (!rstVal || ldVal) begin
      modelPos = 0;
    end else begin
      modelPos    = (modelPos + 1) % 16;
      e.isAdvance = 1'b1;
    end
    e.expY = grayOf(modelPos);
    scoreQ.push_back(e);
  endtask

  // Assert reset a few time units after a rising edge and confirm y clears
  // well before the next rising edge.
  task automatic asyncResetCheck();
    @(posedge clk);
    #2;
    rst = 1'b0;
    modelPos = 0;
    #1;
    checkOutput("asyncResetImmediate", y, 4'b0000);
  endtask

  // Keep stepping with normal advance until the model sits at the given code.
  task automatic advanceTo(input logic [3:0] code);
    int guard;
    guard = 0;
    while (grayOf(modelPos) != code && guard < 32) begin
      applyStimulus(1'b1, 1'b0);
      guard++;
    end
  endtask

  // Monitor: one scoreboard entry is due per falling edge.
  initial begin : monitor
    expect_t    e;
    logic [3:0] prevY;
    bit         havePrev;
    havePrev = 0;
    prevY    = 4'b0000;
    forever begin
      @(negedge clk);
      if (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        checkOutput("scoreboard", y, e.expY);
        if (e.isAdvance && havePrev) begin
          checkCount++;
          if ($countones(y ^ prevY) != 1) begin
            errorCount++;
            $display("[TB] FAIL oneBitChange: y=%b previous=%b at t=%0t",
                     y, prevY, $time);
          end
        end
        prevY    = y;
        havePrev = 1;
      end
    end
  end

  // Absolute time bound so the run can never hang.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int waitCycles;
    rst = 1'b0;
    ld  = 1'b0;

    // Power-up: two cycles in reset, then the first four codes.
    #1;
    checkOutput("resetHeld", y, 4'b0000);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);

    // Full sweep of 17 edges from a fresh reset: every code plus the wrap.
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0);

    // Single-edge load pulse at S5 (0111).
    advanceTo(4'b0111);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);

    // Load held for three edges starting at S10 (1111).
    advanceTo(4'b1111);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);

    // Asynchronous reset between edges at S9 (1101); ld during reset is ignored.
    advanceTo(4'b1101);
    asyncResetCheck();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);

    // Release reset with ld still high, then let it advance.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);

    // Randomized phase: sparse loads, occasional reset, rare async reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        asyncResetCheck();
        applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(($urandom_range(0, 29) != 0),
                      ($urandom_range(0, 9) == 0));
      end
    end

    // Drain the scoreboard with a bounded wait.
    waitCycles = 0;
    while (scoreQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    @(negedge clk);
    #1;
    checkCount++;
    if (scoreQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL drainScoreboard: entries left=%0d required=0",
               scoreQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount,
             errorCount);
    $finish;
  end

endmodule
